// File: rtl/mt_core_frontend_pkg.sv
// rtl/mt_core_frontend_pkg.sv - shared types and constants for the fetch-and-issue frontend
package mt_core_frontend_pkg;

  localparam int unsigned FE_CTX_W   = 2;
  localparam int unsigned FE_ADDR_W  = 32;
  localparam int unsigned FE_INSTR_W = 32;
  localparam int unsigned PC_STEP    = 4;

  typedef enum logic [2:0] {
    CTX_IDLE  = 3'd0,
    CTX_READY = 3'd1,
    CTX_FETCH = 3'd2,
    CTX_PEND  = 3'd3,
    CTX_DONE  = 3'd4
  } ctx_state_t;

  typedef enum logic {
    FE_IDLE = 1'b0,
    FE_REQ  = 1'b1
  } fe_state_t;

  typedef struct packed {
    logic [FE_CTX_W-1:0]   ctx;
    logic [FE_ADDR_W-1:0]  pc;
    logic [FE_INSTR_W-1:0] instr;
  } fe_issue_t;

endpackage

// File: rtl/mt_core_frontend_rr_arbiter.sv
// rtl/mt_core_frontend_rr_arbiter.sv - combinational round-robin arbiter, pointer held by the parent
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last_grant,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    // Search begins just after the previous winner so every requester is served within N grants.
    for (int i = 1; i <= N; i++) begin
      automatic int idx = (int'(last_grant) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/mt_core_frontend.sv
// rtl/mt_core_frontend.sv - barrel-threaded fetch-and-issue sequencer
// Optional per-context retire counters are enabled by defining MT_CORE_FE_PERF_EN.
module mt_core_frontend
  import mt_core_frontend_pkg::*;
#(
  parameter  int NUM_CTX     = 4,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int INSTR_WIDTH = 32,
  localparam int CTX_W       = $clog2(NUM_CTX)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   launch_valid,
  input  logic [CTX_W-1:0]       launch_ctx,
  input  logic [ADDR_WIDTH-1:0]  launch_pc,
  output logic                   launch_accept,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic                   issue_valid,
  output logic [CTX_W-1:0]       issue_ctx,
  output logic [ADDR_WIDTH-1:0]  issue_pc,
  output logic [INSTR_WIDTH-1:0] issue_instr,
  input  logic                   issue_ready,
  input  logic                   cmpl_valid,
  input  logic [CTX_W-1:0]       cmpl_ctx,
  input  logic                   cmpl_redirect,
  input  logic [ADDR_WIDTH-1:0]  cmpl_target,
  input  logic                   cmpl_ret,
  output logic [NUM_CTX-1:0]     ctx_busy,
  output logic [NUM_CTX-1:0]     ctx_done,
  output logic                   all_idle,
  output logic                   err
`ifdef MT_CORE_FE_PERF_EN
  ,
  output logic [NUM_CTX*32-1:0]  perf_instr_cnt
`endif
);

  ctx_state_t            ctx_state_q [NUM_CTX];
  ctx_state_t            ctx_state_d [NUM_CTX];
  logic [ADDR_WIDTH-1:0] ctx_pc_q    [NUM_CTX];
  logic [ADDR_WIDTH-1:0] ctx_pc_d    [NUM_CTX];
  fe_state_t             fe_state_q, fe_state_d;
  logic [CTX_W-1:0]      grant_ctx_q, grant_ctx_d;
  logic [CTX_W-1:0]      last_grant_q, last_grant_d;
  fe_issue_t             slot_q, slot_d;
  logic                  slot_valid_q, slot_valid_d;
  logic                  err_q, err_d;

  logic [NUM_CTX-1:0]    ready_vec;
  logic [NUM_CTX-1:0]    arb_gnt;
  logic [CTX_W-1:0]      arb_idx;
  logic                  launch_free;
  logic                  launch_hit_cmpl;
  logic                  cmpl_ok;

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      ready_vec[i] = (ctx_state_q[i] == CTX_READY);
    end
  end

  rr_arbiter #(.N(NUM_CTX)) u_arb (
    .req        (ready_vec),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  // A completion for the same context takes priority, so a colliding launch is refused.
  always_comb begin
    launch_free     = (ctx_state_q[launch_ctx] == CTX_IDLE) ||
                      (ctx_state_q[launch_ctx] == CTX_DONE);
    launch_hit_cmpl = cmpl_valid && (cmpl_ctx == launch_ctx);
    launch_accept   = launch_valid && launch_free && !launch_hit_cmpl;
    cmpl_ok         = cmpl_valid && (ctx_state_q[cmpl_ctx] == CTX_PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        ctx_state_q[i] <= CTX_IDLE;
        ctx_pc_q[i]    <= '0;
      end
      fe_state_q   <= FE_IDLE;
      grant_ctx_q  <= '0;
      last_grant_q <= CTX_W'(NUM_CTX - 1);
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        ctx_state_q[i] <= ctx_state_d[i];
        ctx_pc_q[i]    <= ctx_pc_d[i];
      end
      fe_state_q   <= fe_state_d;
      grant_ctx_q  <= grant_ctx_d;
      last_grant_q <= last_grant_d;
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      ctx_state_d[i] = ctx_state_q[i];
      ctx_pc_d[i]    = ctx_pc_q[i];
    end
    fe_state_d   = fe_state_q;
    grant_ctx_d  = grant_ctx_q;
    last_grant_d = last_grant_q;
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    err_d        = err_q;

    if (slot_valid_q && issue_ready) begin
      slot_valid_d = 1'b0;
    end

    case (fe_state_q)
      FE_IDLE: begin
        if (!slot_valid_q && (|arb_gnt)) begin
          fe_state_d            = FE_REQ;
          grant_ctx_d           = arb_idx;
          last_grant_d          = arb_idx;
          ctx_state_d[arb_idx]  = CTX_FETCH;
        end
      end
      FE_REQ: begin
        if (imem_valid) begin
          fe_state_d               = FE_IDLE;
          slot_valid_d             = 1'b1;
          slot_d.ctx               = FE_CTX_W'(grant_ctx_q);
          slot_d.pc                = FE_ADDR_W'(ctx_pc_q[grant_ctx_q]);
          slot_d.instr             = FE_INSTR_W'(imem_rdata);
          ctx_state_d[grant_ctx_q] = CTX_PEND;
        end
      end
      default: fe_state_d = FE_IDLE;
    endcase

    if (launch_accept) begin
      ctx_state_d[launch_ctx] = CTX_READY;
      ctx_pc_d[launch_ctx]    = launch_pc & ~ADDR_WIDTH'(3);
    end else if (launch_valid) begin
      err_d = 1'b1;
    end

    if (cmpl_ok) begin
      if (cmpl_ret) begin
        ctx_state_d[cmpl_ctx] = CTX_DONE;
      end else begin
        ctx_state_d[cmpl_ctx] = CTX_READY;
        ctx_pc_d[cmpl_ctx]    = cmpl_redirect ? (cmpl_target & ~ADDR_WIDTH'(3))
                                              : (ctx_pc_q[cmpl_ctx] + ADDR_WIDTH'(PC_STEP));
      end
    end else if (cmpl_valid) begin
      err_d = 1'b1;
    end
  end

  // imem_req decodes straight from the async-reset state flop, so reset drops it at once.
  always_comb begin
    imem_req    = (fe_state_q == FE_REQ);
    imem_addr   = imem_req ? ctx_pc_q[grant_ctx_q] : '0;
    issue_valid = slot_valid_q;
    issue_ctx   = CTX_W'(slot_q.ctx);
    issue_pc    = ADDR_WIDTH'(slot_q.pc);
    issue_instr = INSTR_WIDTH'(slot_q.instr);
    for (int i = 0; i < NUM_CTX; i++) begin
      ctx_busy[i] = (ctx_state_q[i] == CTX_READY) || (ctx_state_q[i] == CTX_FETCH) ||
                    (ctx_state_q[i] == CTX_PEND);
      ctx_done[i] = (ctx_state_q[i] == CTX_DONE);
    end
    all_idle = ~|ctx_busy;
    err      = err_q;
  end

`ifdef MT_CORE_FE_PERF_EN
  logic [31:0] perf_cnt_q [NUM_CTX];
  logic [31:0] perf_cnt_d [NUM_CTX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) perf_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) perf_cnt_q[i] <= perf_cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      perf_cnt_d[i] = perf_cnt_q[i];
      if (launch_accept && (launch_ctx == CTX_W'(i))) begin
        perf_cnt_d[i] = '0;
      end else if (cmpl_ok && (cmpl_ctx == CTX_W'(i)) && (perf_cnt_q[i] != 32'hFFFF_FFFF)) begin
        perf_cnt_d[i] = perf_cnt_q[i] + 32'd1;
      end
      perf_instr_cnt[i*32 +: 32] = perf_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_mt_core_frontend.sv
// tb/tb_mt_core_frontend.sv - self-checking bench: vector table, directed corner sequences, random vs reference model
module tb_mt_core_frontend;

  logic        clk;
  logic        rst_n;
  logic        launch_valid;
  logic [1:0]  launch_ctx;
  logic [31:0] launch_pc;
  logic        launch_accept;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        issue_valid;
  logic [1:0]  issue_ctx;
  logic [31:0] issue_pc;
  logic [31:0] issue_instr;
  logic        issue_ready;
  logic        cmpl_valid;
  logic [1:0]  cmpl_ctx;
  logic        cmpl_redirect;
  logic [31:0] cmpl_target;
  logic        cmpl_ret;
  logic [3:0]  ctx_busy;
  logic [3:0]  ctx_done;
  logic        all_idle;
  logic        err;
`ifdef MT_CORE_FE_PERF_EN
  logic [127:0] perf_instr_cnt;
`endif

  mt_core_frontend dut (
    .clk(clk), .rst_n(rst_n),
    .launch_valid(launch_valid), .launch_ctx(launch_ctx), .launch_pc(launch_pc),
    .launch_accept(launch_accept),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .issue_valid(issue_valid), .issue_ctx(issue_ctx), .issue_pc(issue_pc),
    .issue_instr(issue_instr), .issue_ready(issue_ready),
    .cmpl_valid(cmpl_valid), .cmpl_ctx(cmpl_ctx), .cmpl_redirect(cmpl_redirect),
    .cmpl_target(cmpl_target), .cmpl_ret(cmpl_ret),
    .ctx_busy(ctx_busy), .ctx_done(ctx_done), .all_idle(all_idle), .err(err)
`ifdef MT_CORE_FE_PERF_EN
    , .perf_instr_cnt(perf_instr_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: context states 0=idle 1=ready 2=fetch 3=pend 4=done
  int          m_st [4];
  logic [31:0] m_pc [4];
  bit          m_req;
  int          m_g;
  int          m_last;
  bit          m_sv;
  int          m_sctx;
  logic [31:0] m_spc;
  logic [31:0] m_sinstr;
  bit          m_err;
  int          issued [$];
`ifdef MT_CORE_FE_PERF_EN
  logic [31:0] m_perf [4];
`endif

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_st[k] = 0;
      m_pc[k] = 32'h0;
`ifdef MT_CORE_FE_PERF_EN
      m_perf[k] = 32'h0;
`endif
    end
    m_req = 0; m_g = 0; m_last = 3; m_sv = 0; m_sctx = 0;
    m_spc = 0; m_sinstr = 0; m_err = 0;
    issued.delete();
  endtask

  function automatic bit model_launch_ok();
    int c = int'(launch_ctx);
    return launch_valid && (m_st[c] == 0 || m_st[c] == 4) &&
           !(cmpl_valid && cmpl_ctx == launch_ctx);
  endfunction

  task automatic model_edge();
    bit la  = model_launch_ok();
    bit cok = cmpl_valid && (m_st[int'(cmpl_ctx)] == 3);
    int w   = -1;
    if (!m_req && !m_sv) begin
      for (int k = 1; k <= 4; k++) begin
        int c = (m_last + k) % 4;
        if (w < 0 && m_st[c] == 1) w = c;
      end
    end
    if (m_sv && issue_ready) begin
      issued.push_back(m_sctx);
      m_sv = 0;
    end
    if (m_req && imem_valid) begin
      m_sv = 1; m_sctx = m_g; m_spc = m_pc[m_g]; m_sinstr = imem_rdata;
      m_st[m_g] = 3; m_req = 0;
    end else if (!m_req && w >= 0) begin
      m_req = 1; m_g = w; m_last = w; m_st[w] = 2;
    end
    if (la) begin
      m_st[int'(launch_ctx)] = 1;
      m_pc[int'(launch_ctx)] = {launch_pc[31:2], 2'b00};
`ifdef MT_CORE_FE_PERF_EN
      m_perf[int'(launch_ctx)] = 0;
`endif
    end else if (launch_valid) begin
      m_err = 1;
    end
    if (cok) begin
      int c = int'(cmpl_ctx);
`ifdef MT_CORE_FE_PERF_EN
      if (m_perf[c] != 32'hFFFF_FFFF) m_perf[c] = m_perf[c] + 1;
`endif
      if (cmpl_ret) m_st[c] = 4;
      else begin
        m_st[c] = 1;
        m_pc[c] = cmpl_redirect ? {cmpl_target[31:2], 2'b00} : m_pc[c] + 32'd4;
      end
    end else if (cmpl_valid) begin
      m_err = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] eb, ed;
    for (int k = 0; k < 4; k++) begin
      eb[k] = (m_st[k] inside {1, 2, 3});
      ed[k] = (m_st[k] == 4);
    end
    chk({tag, ".imem_req"}, 32'(imem_req), 32'(m_req));
    if (m_req) chk({tag, ".imem_addr"}, imem_addr, m_pc[m_g]);
    chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(m_sv));
    if (m_sv) begin
      chk({tag, ".issue_ctx"}, 32'(issue_ctx), 32'(m_sctx));
      chk({tag, ".issue_pc"}, issue_pc, m_spc);
      chk({tag, ".issue_instr"}, issue_instr, m_sinstr);
    end
    chk({tag, ".ctx_busy"}, 32'(ctx_busy), 32'(eb));
    chk({tag, ".ctx_done"}, 32'(ctx_done), 32'(ed));
    chk({tag, ".all_idle"}, 32'(all_idle), 32'(eb == 4'b0));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef MT_CORE_FE_PERF_EN
    for (int k = 0; k < 4; k++) chk({tag, ".perf"}, perf_instr_cnt[k*32 +: 32], m_perf[k]);
`endif
  endtask

  task automatic set_idle();
    launch_valid = 0; launch_ctx = 0; launch_pc = 0;
    imem_valid = 0; imem_rdata = 0; issue_ready = 0;
    cmpl_valid = 0; cmpl_ctx = 0; cmpl_redirect = 0; cmpl_target = 0; cmpl_ret = 0;
  endtask

  // Entered and left at posedge+1; inputs must already be applied.
  task automatic cycle(input string tag);
    #2;
    chk({tag, ".launch_accept"}, 32'(launch_accept), 32'(model_launch_ok()));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    model_reset();
    #1;
    check_outputs("reset");
    chk("reset.imem_addr", imem_addr, 32'h0);
    chk("reset.issue_pc", issue_pc, 32'h0);
    chk("reset.issue_instr", issue_instr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_auto(input int p_lv, input int p_iv, input int p_ir,
                            input int p_cv, input int p_bad, input int p_ret);
    launch_valid  = ($urandom_range(0, 99) < p_lv);
    launch_ctx    = 2'($urandom_range(0, 3));
    launch_pc     = $urandom;
    imem_valid    = m_req && ($urandom_range(0, 99) < p_iv);
    imem_rdata    = $urandom;
    issue_ready   = ($urandom_range(0, 99) < p_ir);
    cmpl_valid    = 0;
    cmpl_ctx      = 0;
    cmpl_redirect = ($urandom_range(0, 3) == 0);
    cmpl_target   = $urandom;
    cmpl_ret      = ($urandom_range(0, 99) < p_ret);
    if (issued.size() > 0 && $urandom_range(0, 99) < p_cv) begin
      cmpl_valid = 1;
      cmpl_ctx   = 2'(issued.pop_front());
    end else if ($urandom_range(0, 99) < p_bad) begin
      cmpl_valid = 1;
      cmpl_ctx   = 2'($urandom_range(0, 3));
    end
  endtask

  localparam int OP_NONE = 0, OP_LAUNCH = 1, OP_IMEM = 2, OP_ISSUE = 3,
                 OP_CMPL = 4, OP_RET = 5, OP_REDIR = 6, OP_LC = 7;

  typedef struct {
    int          op;
    logic [1:0]  c;
    logic [31:0] v;
    logic        e_la;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_isv;
    logic [31:0] e_ipc;
    logic [3:0]  e_busy;
    logic [3:0]  e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl [$];

  task automatic add_row(input int op, input logic [1:0] c, input logic [31:0] v,
                         input logic la, input logic req, input logic [31:0] addr,
                         input logic isv, input logic [31:0] ipc,
                         input logic [3:0] busy, input logic [3:0] done, input logic e);
    vec_t r;
    r.op = op; r.c = c; r.v = v; r.e_la = la; r.e_req = req; r.e_addr = addr;
    r.e_isv = isv; r.e_ipc = ipc; r.e_busy = busy; r.e_done = done; r.e_err = e;
    tbl.push_back(r);
  endtask

  task automatic apply_op(input vec_t r);
    set_idle();
    case (r.op)
      OP_LAUNCH: begin launch_valid = 1; launch_ctx = r.c; launch_pc = r.v; end
      OP_IMEM:   begin imem_valid = 1; imem_rdata = r.v; end
      OP_ISSUE:  issue_ready = 1;
      OP_CMPL:   begin cmpl_valid = 1; cmpl_ctx = r.c; end
      OP_RET:    begin cmpl_valid = 1; cmpl_ctx = r.c; cmpl_ret = 1; end
      OP_REDIR:  begin cmpl_valid = 1; cmpl_ctx = r.c; cmpl_redirect = 1; cmpl_target = r.v; end
      OP_LC:     begin launch_valid = 1; launch_ctx = r.c; launch_pc = r.v;
                       cmpl_valid = 1; cmpl_ctx = r.c; end
      default:   ;
    endcase
  endtask

  logic [31:0] exp_ord [5];
  logic [31:0] hold_pc;
  int          ord_k;
  bit          prev_req;

  initial begin
    rst_n = 1'b1;
    set_idle();
    #2;

    // Basic flow, PC wrap, redirect alignment and error cases as a vector table.
    add_row(OP_LAUNCH, 0, 32'h0000_0103, 1, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_NONE,   0, 0,             0, 1, 32'h0000_0100, 0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_IMEM,   0, 32'h1111_0000, 0, 0, 0,             1, 32'h0000_0100, 4'b0001, 4'b0000, 0);
    add_row(OP_ISSUE,  0, 0,             0, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_CMPL,   0, 0,             0, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_NONE,   0, 0,             0, 1, 32'h0000_0104, 0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_IMEM,   0, 32'h2222_0000, 0, 0, 0,             1, 32'h0000_0104, 4'b0001, 4'b0000, 0);
    add_row(OP_ISSUE,  0, 0,             0, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_RET,    0, 0,             0, 0, 0,             0, 0,             4'b0000, 4'b0001, 0);
    add_row(OP_LAUNCH, 0, 32'hFFFF_FFFE, 1, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_NONE,   0, 0,             0, 1, 32'hFFFF_FFFC, 0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_IMEM,   0, 32'h3333_0000, 0, 0, 0,             1, 32'hFFFF_FFFC, 4'b0001, 4'b0000, 0);
    add_row(OP_ISSUE,  0, 0,             0, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_CMPL,   0, 0,             0, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_NONE,   0, 0,             0, 1, 32'h0000_0000, 0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_IMEM,   0, 32'h4444_0000, 0, 0, 0,             1, 32'h0000_0000, 4'b0001, 4'b0000, 0);
    add_row(OP_ISSUE,  0, 0,             0, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_REDIR,  0, 32'h0000_0FF3, 0, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_NONE,   0, 0,             0, 1, 32'h0000_0FF0, 0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_IMEM,   0, 32'h5555_0000, 0, 0, 0,             1, 32'h0000_0FF0, 4'b0001, 4'b0000, 0);
    add_row(OP_ISSUE,  0, 0,             0, 0, 0,             0, 0,             4'b0001, 4'b0000, 0);
    add_row(OP_RET,    0, 0,             0, 0, 0,             0, 0,             4'b0000, 4'b0001, 0);
    add_row(OP_CMPL,   2, 0,             0, 0, 0,             0, 0,             4'b0000, 4'b0001, 1);
    add_row(OP_LC,     0, 32'h0000_0040, 0, 0, 0,             0, 0,             4'b0000, 4'b0001, 1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply_op(tbl[i]);
      #1;
      chk($sformatf("tbl%0d.launch_accept", i), 32'(launch_accept), 32'(tbl[i].e_la));
      cycle($sformatf("tbl%0d.model", i));
      chk($sformatf("tbl%0d.imem_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("tbl%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.issue_valid", i), 32'(issue_valid), 32'(tbl[i].e_isv));
      if (tbl[i].e_isv) chk($sformatf("tbl%0d.issue_pc", i), issue_pc, tbl[i].e_ipc);
      chk($sformatf("tbl%0d.ctx_busy", i), 32'(ctx_busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.ctx_done", i), 32'(ctx_done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d.all_idle", i), 32'(all_idle), 32'(tbl[i].e_busy == 4'b0));
      chk($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].e_err));
    end

    // Four contexts completing immediately: fetch order 0,1,2,3,0.
    do_reset();
    exp_ord[0] = 32'h000; exp_ord[1] = 32'h100; exp_ord[2] = 32'h200;
    exp_ord[3] = 32'h300; exp_ord[4] = 32'h004;
    ord_k = 0;
    prev_req = 0;
    for (int i = 0; i < 60; i++) begin
      drive_auto(0, 100, 100, 100, 0, 0);
      if (i < 4) begin
        launch_valid = 1;
        launch_ctx   = 2'(i);
        launch_pc    = 32'(i) * 32'h100;
      end
      cycle("rr");
      if (imem_req && !prev_req && ord_k < 5) begin
        chk($sformatf("rr.order%0d", ord_k), imem_addr, exp_ord[ord_k]);
        ord_k++;
      end
      prev_req = imem_req;
    end
    chk("rr.fetch_count", 32'(ord_k), 32'd5);

    // Stalled issue slot blocks further fetches; release lets ctx1 fetch.
    do_reset();
    set_idle(); launch_valid = 1; launch_ctx = 0; launch_pc = 32'h500; cycle("stall.l0");
    set_idle(); launch_valid = 1; launch_ctx = 1; launch_pc = 32'h600; cycle("stall.l1");
    set_idle(); cycle("stall.grant");
    chk("stall.req0_addr", imem_addr, 32'h500);
    set_idle(); imem_valid = 1; imem_rdata = 32'hCAFE_0001; cycle("stall.fill");
    hold_pc = 32'h500;
    for (int i = 0; i < 5; i++) begin
      set_idle(); cycle("stall.hold");
      chk("stall.no_req", 32'(imem_req), 32'd0);
      chk("stall.slot_held", 32'(issue_valid), 32'd1);
      chk("stall.slot_pc", issue_pc, hold_pc);
      chk("stall.slot_instr", issue_instr, 32'hCAFE_0001);
    end
    set_idle(); issue_ready = 1; cycle("stall.release");
    set_idle(); cycle("stall.regrant");
    set_idle(); cycle("stall.req1");
    chk("stall.req1", 32'(imem_req), 32'd1);
    chk("stall.req1_addr", imem_addr, 32'h600);

    // Launch to a PEND context is refused and flags err; ctx1 is mid-fetch.
    set_idle(); launch_valid = 1; launch_ctx = 0; launch_pc = 32'h900;
    #1;
    chk("busy_launch.accept", 32'(launch_accept), 32'd0);
    cycle("busy_launch");
    chk("busy_launch.err", 32'(err), 32'd1);
    chk("busy_launch.busy", 32'(ctx_busy), 32'b0011);
    chk("busy_launch.req_held", imem_addr, 32'h600);

    // Reset in the middle of FE_REQ; do_reset checks outputs before any clock edge.
    chk("midreset.pre_req", 32'(imem_req), 32'd1);
    do_reset();

    // Randomized traffic against the model, with periodic resets to clear err.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        drive_auto(15, 60, 70, 40, 3, 15);
        cycle("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
